// File: rtl/sample_readout_pkg.sv
// Shared types and helpers for the sample readout path.
package sample_readout_pkg;

  localparam int unsigned NUM_BUCKETS = 16;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic {
    STREAM    = 1'b0,
    HIST_DUMP = 1'b1
  } state_e;

  // Increment that holds at 2^w-1; callers cast to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v == lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sample_readout_if.sv
// Sample push, readout stream and dump handshake between monitor/host and sample_readout.
interface sample_readout_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic                                  smp_valid;
  logic [DATA_W-1:0]                     smp_data;
  logic                                  rd_valid;
  logic                                  rd_ready;
  logic [CNT_W-1:0]                      rd_data;
  logic                                  rd_is_hist;
  logic [sample_readout_pkg::IDX_W-1:0]  rd_index;
  logic                                  dump_req;
  logic                                  dump_busy;

  modport master (
    output smp_valid, smp_data, rd_ready, dump_req,
    input  rd_valid, rd_data, rd_is_hist, rd_index, dump_busy
  );

  modport slave (
    input  smp_valid, smp_data, rd_ready, dump_req,
    output rd_valid, rd_data, rd_is_hist, rd_index, dump_busy
  );
endinterface

// File: rtl/sample_ring.sv
// Circular sample buffer; exposes next-cycle head-of-queue data so the parent can register it.
module sample_ring #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   nxt_level_c,
  output logic [DATA_W-1:0]        nxt_rdata_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  // A pop frees a slot in the same cycle, so push+pop is legal when full.
  always_comb begin
    full_c  = (level_q == LVL_W'(DEPTH));
    do_pop  = pop && (level_q != '0) && !clear;
    do_push = push && (!full_c || do_pop) && !clear;
    head_d  = head_q + PTR_W'(do_push);
    tail_d  = tail_q + PTR_W'(do_pop);
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
    nxt_level_c = level_d;
    nxt_rdata_c = (do_push && (head_q == tail_d)) ? wdata : mem_q[tail_d];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[head_q] <= wdata;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sample_readout.sv
// Drains the sample ring over a valid/ready stream, keeps drain statistics and dumps the histogram.
module sample_readout
  import sample_readout_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SUM_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  sample_readout_if.slave         bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        drop_count,
  output logic [CNT_W-1:0]        pop_count,
  output logic [SUM_W-1:0]        sum,
  output logic [DATA_W-1:0]       max_val,
  output logic [DATA_W-1:0]       min_val
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  hist_q [NUM_BUCKETS];
  logic [CNT_W-1:0]  hist_d [NUM_BUCKETS];
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d, drop_q, drop_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] max_q, max_d, min_q, min_d;
  logic              rd_valid_q, rd_valid_d, rd_hist_q, rd_hist_d, busy_q, busy_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  logic              pop, full_c;
  logic [LVL_W-1:0]  nxt_level_c;
  logic [DATA_W-1:0] nxt_rdata_c, pop_data;

  assign pop      = (state_q == STREAM) && rd_valid_q && bus.rd_ready;
  assign pop_data = rd_data_q[DATA_W-1:0];

  sample_ring #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push        (bus.smp_valid),
    .pop         (pop),
    .wdata       (bus.smp_data),
    .full_c      (full_c),
    .level       (level),
    .nxt_level_c (nxt_level_c),
    .nxt_rdata_c (nxt_rdata_c)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hist_d    = hist_q;
    pop_cnt_d = pop_cnt_q;
    drop_d    = drop_q;
    sum_d     = sum_q;
    max_d     = max_q;
    min_d     = min_q;

    if (pop) begin
      pop_cnt_d = CNT_W'(sat_inc(32'(pop_cnt_q), CNT_W));
      sum_d     = sum_q + SUM_W'(pop_data);
      if (pop_data > max_q) max_d = pop_data;
      if (pop_data < min_q) min_d = pop_data;
      hist_d[pop_data[IDX_W-1:0]] = CNT_W'(sat_inc(32'(hist_q[pop_data[IDX_W-1:0]]), CNT_W));
    end

    if (bus.smp_valid && full_c && !pop) begin
      drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
    end

    case (state_q)
      STREAM: begin
        if (bus.dump_req) begin
          state_d = HIST_DUMP;
          idx_d   = '0;
        end
      end
      HIST_DUMP: begin
        if (bus.rd_ready) begin
          if (idx_q == IDX_W'(NUM_BUCKETS - 1)) begin
            state_d = STREAM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = STREAM;
    endcase

    // Output beat is built from next-cycle state so every rd_* signal is a flop.
    busy_d    = (state_d == HIST_DUMP);
    rd_hist_d = busy_d;
    if (busy_d) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hist_d[idx_d];
    end else begin
      rd_valid_d = (nxt_level_c != '0);
      rd_data_d  = CNT_W'(nxt_rdata_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= STREAM;
      idx_q      <= '0;
      for (int i = 0; i < NUM_BUCKETS; i++) hist_q[i] <= '0;
      pop_cnt_q  <= '0;
      drop_q     <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      min_q      <= '1;
      rd_valid_q <= 1'b0;
      rd_hist_q  <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hist_q     <= hist_d;
      pop_cnt_q  <= pop_cnt_d;
      drop_q     <= drop_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      min_q      <= min_d;
      rd_valid_q <= rd_valid_d;
      rd_hist_q  <= rd_hist_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_is_hist = rd_hist_q;
  assign bus.rd_index   = idx_q;
  assign bus.dump_busy  = busy_q;
  assign drop_count     = drop_q;
  assign pop_count      = pop_cnt_q;
  assign sum            = sum_q;
  assign max_val        = max_q;
  assign min_val        = min_q;

endmodule

// File: tb/tb_sample_readout.sv
// Scenario and randomized bench for sample_readout with a queue-based reference model.
module tb_sample_readout;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SUM_W  = 24;

  logic              clk = 1'b0;
  logic              rst, clear;
  logic [3:0]        level;
  logic [CNT_W-1:0]  drop_count, pop_count;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] max_val, min_val;

  sample_readout_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  sample_readout #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus.slave),
    .level      (level),
    .drop_count (drop_count),
    .pop_count  (pop_count),
    .sum        (sum),
    .max_val    (max_val),
    .min_val    (min_val)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain FIFO queue plus running statistics.
  int mq[$];
  bit m_dump;
  int m_idx, m_pop, m_drop, m_max, m_min;
  longint m_sum;
  int m_hist[16];

  task automatic model_step();
    bit pop_now, push_ok;
    int d;
    if (rst || clear) begin
      mq.delete();
      m_dump = 0; m_idx = 0; m_pop = 0; m_drop = 0; m_sum = 0; m_max = 0; m_min = 255;
      foreach (m_hist[i]) m_hist[i] = 0;
      return;
    end
    pop_now = !m_dump && (mq.size() != 0) && bus.rd_ready;
    if (m_dump) begin
      if (bus.rd_ready) begin
        if (m_idx == 15) begin m_dump = 0; m_idx = 0; end
        else m_idx++;
      end
    end else if (bus.dump_req) begin
      m_dump = 1; m_idx = 0;
    end
    push_ok = bus.smp_valid && ((mq.size() < DEPTH) || pop_now);
    if (pop_now) begin
      d = mq.pop_front();
      if (m_pop < 65535) m_pop++;
      m_sum = (m_sum + d) % (longint'(1) << 24);
      if (d > m_max) m_max = d;
      if (d < m_min) m_min = d;
      if (m_hist[d % 16] < 65535) m_hist[d % 16]++;
    end
    if (bus.smp_valid && !push_ok && m_drop < 65535) m_drop++;
    if (push_ok) mq.push_back(int'(bus.smp_data));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; clear = 0;
    bus.smp_valid = 0; bus.smp_data = '0; bus.rd_ready = 0; bus.dump_req = 0;
    tick(); tick();
    rst = 0;
    checks++;
    if ({bus.rd_valid, bus.rd_is_hist, bus.dump_busy, bus.rd_index} !== 7'h0) begin
      errors++; $display("FAIL reset_flags got %b exp 0", {bus.rd_valid, bus.rd_is_hist, bus.dump_busy, bus.rd_index});
    end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++;
    if ({drop_count, pop_count, sum, max_val} !== '0) begin
      errors++; $display("FAIL reset_stats got drop=%0d pop=%0d sum=%0d max=%0h exp all 0", drop_count, pop_count, sum, max_val);
    end
    checks++;
    if (min_val !== 8'hFF) begin errors++; $display("FAIL reset_min got %0h exp ff", min_val); end
  endtask

  task automatic test_push_visible();
    bus.smp_valid = 1; bus.smp_data = 8'h12; tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0012) begin
      errors++; $display("FAIL first_push_visible got v=%b d=%0h exp v=1 d=12", bus.rd_valid, bus.rd_data);
    end
    bus.smp_data = 8'h15; tick();
    bus.smp_data = 8'h18; tick();
    bus.smp_valid = 0; tick(); tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0012) begin
      errors++; $display("FAIL held_data got v=%b d=%0h exp v=1 d=12", bus.rd_valid, bus.rd_data);
    end
    checks++;
    if (level !== 4'd3) begin errors++; $display("FAIL level3 got %0d exp 3", level); end
  endtask

  task automatic test_drain_stats();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h12; exp_q[1] = 8'h15; exp_q[2] = 8'h18;
    bus.rd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'(exp_q[i])) begin
        errors++; $display("FAIL drain_order[%0d] got v=%b d=%0h exp d=%0h", i, bus.rd_valid, bus.rd_data, exp_q[i]);
      end
      tick();
    end
    bus.rd_ready = 0;
    checks++;
    if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got v=%b exp 0", bus.rd_valid); end
    checks++;
    if (pop_count !== 16'd3 || sum !== 24'd63) begin
      errors++; $display("FAIL drain_pop_sum got pop=%0d sum=%0d exp pop=3 sum=63", pop_count, sum);
    end
    checks++;
    if (max_val !== 8'h18 || min_val !== 8'h12) begin
      errors++; $display("FAIL drain_minmax got max=%0h min=%0h exp max=18 min=12", max_val, min_val);
    end
  endtask

  task automatic test_dump();
    int beats, expv;
    bus.dump_req = 1; tick(); bus.dump_req = 0;
    beats = 0;
    for (int cyc = 0; cyc < 64 && beats < 16; cyc++) begin
      expv = (beats == 2 || beats == 5 || beats == 8) ? 1 : 0;
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_is_hist !== 1'b1 || bus.dump_busy !== 1'b1 ||
          bus.rd_index !== 4'(beats) || bus.rd_data !== 16'(expv)) begin
        errors++;
        $display("FAIL dump_beat[%0d] got v=%b h=%b busy=%b idx=%0d d=%0d exp v=1 h=1 busy=1 idx=%0d d=%0d",
                 beats, bus.rd_valid, bus.rd_is_hist, bus.dump_busy, bus.rd_index, bus.rd_data, beats, expv);
      end
      bus.rd_ready = (cyc % 2 == 0);
      tick();
      if (bus.rd_ready) beats++;
    end
    bus.rd_ready = 0;
    checks++;
    if (beats != 16) begin errors++; $display("FAIL dump_beat_count got %0d exp 16", beats); end
    checks++;
    if (bus.dump_busy !== 1'b0 || bus.rd_is_hist !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL dump_exit got busy=%b h=%b v=%b exp 0 0 0", bus.dump_busy, bus.rd_is_hist, bus.rd_valid);
    end
  endtask

  task automatic test_overflow();
    bus.smp_valid = 1;
    for (int i = 0; i < 10; i++) begin
      bus.smp_data = 8'(8'hA0 + i);
      tick();
    end
    bus.smp_valid = 0;
    checks++;
    if (level !== 4'd8 || drop_count !== 16'd2) begin
      errors++; $display("FAIL overflow got level=%0d drop=%0d exp level=8 drop=2", level, drop_count);
    end
    checks++;
    if (bus.rd_data !== 16'h00A0) begin errors++; $display("FAIL overflow_head got %0h exp a0", bus.rd_data); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] expv;
    bus.smp_valid = 1; bus.smp_data = 8'hEE; bus.rd_ready = 1; tick();
    bus.smp_valid = 0; bus.rd_ready = 0;
    checks++;
    if (level !== 4'd8 || drop_count !== 16'd2) begin
      errors++; $display("FAIL full_push_pop got level=%0d drop=%0d exp level=8 drop=2", level, drop_count);
    end
    bus.rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      expv = (i == 7) ? 8'hEE : 8'(8'hA1 + i);
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'(expv)) begin
        errors++; $display("FAIL full_drain[%0d] got v=%b d=%0h exp d=%0h", i, bus.rd_valid, bus.rd_data, expv);
      end
      tick();
    end
    bus.rd_ready = 0;
    checks++;
    if (level !== 4'd0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL full_drain_empty got level=%0d v=%b exp 0 0", level, bus.rd_valid);
    end
  endtask

  task automatic test_clear_mid_dump();
    bus.smp_valid = 1; bus.smp_data = 8'h33; tick();
    bus.smp_data = 8'h44; tick();
    bus.smp_valid = 0;
    bus.dump_req = 1; tick(); bus.dump_req = 0;
    bus.rd_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.rd_index !== 4'd5 || bus.dump_busy !== 1'b1) begin
      errors++; $display("FAIL pre_clear got idx=%0d busy=%b exp idx=5 busy=1", bus.rd_index, bus.dump_busy);
    end
    clear = 1; bus.smp_valid = 1; bus.smp_data = 8'h77; tick();
    clear = 0; bus.smp_valid = 0; bus.rd_ready = 0;
    checks++;
    if ({bus.rd_valid, bus.rd_is_hist, bus.dump_busy, bus.rd_index} !== 7'h0 || level !== 4'd0) begin
      errors++; $display("FAIL clear_flags got v=%b h=%b busy=%b idx=%0d level=%0d exp all 0",
                         bus.rd_valid, bus.rd_is_hist, bus.dump_busy, bus.rd_index, level);
    end
    checks++;
    if ({drop_count, pop_count, sum, max_val} !== '0 || min_val !== 8'hFF) begin
      errors++; $display("FAIL clear_stats got drop=%0d pop=%0d sum=%0d max=%0h min=%0h exp 0 0 0 0 ff",
                         drop_count, pop_count, sum, max_val, min_val);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL clear_push_discarded got v=%b level=%0d exp 0 0", bus.rd_valid, level);
    end
  endtask

  task automatic test_random();
    int rdy_pct;
    bit exp_valid;
    rst = 1; tick(); rst = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rdy_pct = ((cyc / 100) % 2 == 0) ? 30 : 85;
      bus.smp_valid = ($urandom_range(0, 99) < 55);
      bus.smp_data  = 8'($urandom);
      bus.rd_ready  = ($urandom_range(0, 99) < rdy_pct);
      bus.dump_req  = ($urandom_range(0, 99) < 3);
      clear         = ($urandom_range(0, 299) == 0);
      tick();
      exp_valid = m_dump || (mq.size() != 0);
      checks++;
      if (bus.rd_valid !== exp_valid || bus.rd_is_hist !== m_dump || bus.dump_busy !== m_dump ||
          bus.rd_index !== 4'(m_idx)) begin
        errors++; $display("FAIL rand_ctrl[%0d] got v=%b h=%b busy=%b idx=%0d exp v=%b h=%b busy=%b idx=%0d",
                           cyc, bus.rd_valid, bus.rd_is_hist, bus.dump_busy, bus.rd_index,
                           exp_valid, m_dump, m_dump, m_idx);
      end
      if (exp_valid) begin
        checks++;
        if (bus.rd_data !== (m_dump ? 16'(m_hist[m_idx]) : 16'(mq[0]))) begin
          errors++; $display("FAIL rand_data[%0d] got %0h exp %0h", cyc, bus.rd_data,
                             m_dump ? 16'(m_hist[m_idx]) : 16'(mq[0]));
        end
      end
      checks++;
      if (level !== 4'(mq.size()) || drop_count !== 16'(m_drop) || pop_count !== 16'(m_pop) ||
          sum !== 24'(m_sum) || max_val !== 8'(m_max) || min_val !== 8'(m_min)) begin
        errors++; $display("FAIL rand_stats[%0d] got lvl=%0d drop=%0d pop=%0d sum=%0d max=%0h min=%0h exp lvl=%0d drop=%0d pop=%0d sum=%0d max=%0h min=%0h",
                           cyc, level, drop_count, pop_count, sum, max_val, min_val,
                           mq.size(), m_drop, m_pop, m_sum, m_max, m_min);
      end
    end
    bus.smp_valid = 0; bus.rd_ready = 0; bus.dump_req = 0; clear = 0;
  endtask

  initial begin
    test_reset();
    test_push_visible();
    test_drain_stats();
    test_dump();
    test_overflow();
    test_full_push_pop();
    test_clear_mid_dump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
